// File: rtl/qf_spi_flash_emu.sv
`default_nettype none
// ============================================================================
// Module   : qf_spi_flash_emu
// Purpose  : Oversampled SPI mode-0 slave emulating a small NOR flash
//            (READ, FAST_READ, RDID, RDSR, WREN/WRDI, PP, SE) with a backdoor
//            load port for preloading the array.
// Ports    : CLK, RST          system clock, synchronous active-high reset
//            csb/sclk/mosi_value  asynchronous SPI pins (synchronised here)
//            miso, miso_oe     SPI data out and its drive enable
//            load_en/addr/data backdoor byte write, wins over flash writes
//            busy              erase in progress (WIP)
// Revision : 1.0  initial release
// ============================================================================
module qf_spi_flash_emu #(
    parameter int          MEM_AW     = 12,
    parameter int          ADDR_BYTES = 3,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter int          FAST_DUMMY = 8,
    parameter int          PAGE_AW    = 8,
    parameter int          SECTOR_AW  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              csb_value,
    input  logic              sclk_value,
    input  logic              mosi_value,
    output logic              miso,
    output logic              miso_oe,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy
);

    localparam int                c_abits     = ADDR_BYTES * 8;
    localparam int                c_depth     = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] c_page_mask = MEM_AW'((1 << PAGE_AW) - 1);
    localparam logic [MEM_AW-1:0] c_sect_mask = MEM_AW'((1 << SECTOR_AW) - 1);

    localparam logic [7:0] c_op_read  = 8'h03;
    localparam logic [7:0] c_op_fast  = 8'h0B;
    localparam logic [7:0] c_op_rdid  = 8'h9F;
    localparam logic [7:0] c_op_rdsr  = 8'h05;
    localparam logic [7:0] c_op_wren  = 8'h06;
    localparam logic [7:0] c_op_wrdi  = 8'h04;
    localparam logic [7:0] c_op_pp    = 8'h02;
    localparam logic [7:0] c_op_se    = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DOUT, S_DOUT_ID,
        S_DOUT_SR, S_HOLD, S_DIN, S_IGNORE
    } state_t;

    state_t r_state, w_next, w_decode;

    // ---------------- pin synchronisers and edge strobes -------------------
    logic [2:0] r_csb_sync, r_sclk_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_csb_sync  <= 3'b111;
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_csb_sync  <= {r_csb_sync[1:0], csb_value};
            r_sclk_sync <= {r_sclk_sync[1:0], sclk_value};
            r_mosi_sync <= {r_mosi_sync[0], mosi_value};
        end
    end

    logic w_csb, w_csb_rise, w_csb_fall, w_sclk_rise, w_sclk_fall, w_mosi;
    assign w_csb       = r_csb_sync[1];
    assign w_csb_rise  =  r_csb_sync[1] & ~r_csb_sync[2];
    assign w_csb_fall  = ~r_csb_sync[1] &  r_csb_sync[2];
    assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    // ---------------- datapath registers -----------------------------------
    logic [7:0]           r_cnt;       // SCLK rises in the current state
    logic [6:0]           r_shift;     // partial incoming byte
    logic [7:0]           r_op;
    logic [MEM_AW-2:0]    r_addr_sh;   // only the low MEM_AW address bits survive
    logic [MEM_AW-1:0]    r_addr;
    logic [7:0]           r_tx;
    logic [2:0]           r_txcnt;
    logic [1:0]           r_id_idx;
    logic                 r_hold_ok;   // no rise seen since entering HOLD
    logic                 r_wel, r_wip;
    logic [SECTOR_AW-1:0] r_ecnt;
    logic [MEM_AW-1:0]    r_ebase;
    logic [7:0]           r_mem [c_depth];

    logic [7:0]        w_byte;
    logic              w_cnt_byte;
    logic [MEM_AW-1:0] w_addr_next, w_eaddr, w_page_inc;
    logic [7:0]        w_tx_byte, w_id_byte;
    logic              w_pp_wr;

    assign w_byte      = {r_shift, w_mosi};
    assign w_cnt_byte  = (r_cnt[2:0] == 3'd7);
    assign w_addr_next = {r_addr_sh, w_mosi};
    assign w_eaddr     = r_ebase | MEM_AW'(r_ecnt);
    assign w_page_inc  = (r_addr & ~c_page_mask) | ((r_addr + 1'b1) & c_page_mask);
    assign w_pp_wr     = ~w_csb & w_sclk_rise & (r_state == S_DIN) & w_cnt_byte & r_wel;
    assign busy        = r_wip;
    assign miso        = r_tx[7];

    always_comb begin
        case (r_id_idx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
        case (r_state)
            S_DOUT:    w_tx_byte = r_mem[r_addr];
            S_DOUT_ID: w_tx_byte = w_id_byte;
            S_DOUT_SR: w_tx_byte = {6'b0, r_wel, r_wip};
            default:   w_tx_byte = 8'h00;
        endcase
    end

    // ---------------- FSM -------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_decode = S_IGNORE;
        miso_oe  = (r_state == S_DOUT) || (r_state == S_DOUT_ID) || (r_state == S_DOUT_SR);
        if (r_wip) begin
            // an erase is running: only status polling is honoured
            if (w_byte == c_op_rdsr) w_decode = S_DOUT_SR;
        end else begin
            case (w_byte)
                c_op_read, c_op_fast, c_op_pp, c_op_se: w_decode = S_ADDR;
                c_op_rdid:                              w_decode = S_DOUT_ID;
                c_op_rdsr:                              w_decode = S_DOUT_SR;
                c_op_wren, c_op_wrdi:                   w_decode = S_HOLD;
                default:                                w_decode = S_IGNORE;
            endcase
        end
        if (w_csb) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_csb_fall) w_next = S_CMD;
                S_CMD:   if (w_sclk_rise && w_cnt_byte) w_next = w_decode;
                S_ADDR: begin
                    if (w_sclk_rise && r_cnt == 8'(c_abits - 1)) begin
                        if (r_op == c_op_fast)    w_next = (FAST_DUMMY == 0) ? S_DOUT : S_DUMMY;
                        else if (r_op == c_op_pp) w_next = S_DIN;
                        else if (r_op == c_op_se) w_next = S_HOLD;
                        else                      w_next = S_DOUT;
                    end
                end
                S_DUMMY: if (w_sclk_rise && r_cnt == 8'(FAST_DUMMY - 1)) w_next = S_DOUT;
                default: w_next = r_state;
            endcase
        end
    end

    // ---------------- datapath / status ------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0; r_shift <= '0; r_op <= '0; r_addr_sh <= '0; r_addr <= '0;
            r_tx <= '0; r_txcnt <= '0; r_id_idx <= '0; r_hold_ok <= 1'b0;
            r_wel <= 1'b0; r_wip <= 1'b0; r_ecnt <= '0; r_ebase <= '0;
        end else begin
            if (r_wip) begin
                r_ecnt <= r_ecnt + 1'b1;
                if (&r_ecnt) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end
            end
            if (w_csb) begin
                r_cnt   <= '0;
                r_tx    <= '0;
                r_txcnt <= '0;
            end else begin
                if (w_sclk_rise) begin
                    r_shift   <= w_byte[6:0];
                    r_cnt     <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
                    r_hold_ok <= (w_next == S_HOLD) && (r_state != S_HOLD);
                    if (r_state == S_CMD && w_cnt_byte) r_op <= w_byte;
                    if (r_state == S_ADDR) begin
                        r_addr_sh <= w_addr_next[MEM_AW-2:0];
                        if (w_next != r_state) r_addr <= w_addr_next;
                    end
                    if (r_state == S_DIN && w_cnt_byte) r_addr <= w_page_inc;
                    if (w_next != r_state) begin
                        r_txcnt  <= '0;
                        r_id_idx <= '0;
                    end
                end
                if (w_sclk_fall && miso_oe) begin
                    if (r_txcnt == 3'd0) begin
                        r_tx <= w_tx_byte;
                        if (r_state == S_DOUT) r_addr <= r_addr + 1'b1;
                        if (r_state == S_DOUT_ID && r_id_idx != 2'd3) r_id_idx <= r_id_idx + 1'b1;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                    r_txcnt <= r_txcnt + 1'b1;
                end
            end
            // commands that act when chip select is released
            if (w_csb_rise) begin
                if (r_state == S_HOLD && r_hold_ok && r_op == c_op_wren) r_wel <= 1'b1;
                if (r_state == S_HOLD && r_hold_ok && r_op == c_op_wrdi) r_wel <= 1'b0;
                if ((r_state == S_ADDR || r_state == S_DIN) && r_op == c_op_pp) r_wel <= 1'b0;
                if (r_state == S_HOLD && r_op == c_op_se && r_wel) begin
                    r_wip   <= 1'b1;
                    r_ecnt  <= '0;
                    r_ebase <= r_addr & ~c_sect_mask;
                end
            end
        end
    end

    // ---------------- memory array (not reset) -----------------------------
    always_ff @(posedge CLK) begin
        if (load_en)             r_mem[load_addr] <= load_data;
        else if (!RST && r_wip)  r_mem[w_eaddr]   <= 8'hFF;
        else if (!RST && w_pp_wr) r_mem[r_addr]   <= r_mem[r_addr] & w_byte;
    end

endmodule
`default_nettype wire
